// File: rtl/risc_v_mike_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the word-aligned fetch address
// into a zero-latency instruction memory and fills the IF/ID register.
// Handles stalls, flushing redirects and a sticky misaligned-target trap.
module risc_v_mike_fetch_unit #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rd_data,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [PC_W-1:0]    if_id_pc_plus4,
  output logic               fetch_halt,
  output logic [31:0]        fetch_cnt
);

  localparam int unsigned     CNT_W   = 32;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 valid_q, valid_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [PC_W-1:0]      id_pc_q, id_pc_d;
  logic [PC_W-1:0]      id_pc_plus4_q, id_pc_plus4_d;
  logic                 halt_q, halt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [PC_W-1:0]      pc_plus4;
  logic                 redirect_misaligned;

  assign pc_plus4            = pc_q + PC_STEP;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

  // Next-state / next-value logic; every field holds unless a rule updates it
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    valid_d       = valid_q;
    instr_d       = instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    halt_d        = halt_q;
    cnt_d         = cnt_q;

    unique case (state_q)
      ST_BOOT, ST_RUN: begin
        if (redirect_valid && redirect_misaligned) begin
          // Trap: freeze the PC, drop the IF/ID contents to a bubble
          state_d = ST_HALT;
          halt_d  = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (redirect_valid) begin
          // Redirect beats stall; IF/ID becomes a bubble, its PC fields hold
          state_d = ST_RUN;
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end else if (state_q == ST_BOOT) begin
          state_d = ST_RUN;
        end else if (!stall) begin
          valid_d       = 1'b1;
          instr_d       = imem_rd_data;
          id_pc_d       = pc_q;
          id_pc_plus4_d = pc_plus4;
          pc_d          = pc_plus4;
          cnt_d         = cnt_q + CNT_W'(1);
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
        halt_d  = 1'b1;
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    endcase
  end

  // State and IF/ID registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      valid_q       <= 1'b0;
      instr_q       <= NOP_INSTR;
      id_pc_q       <= '0;
      id_pc_plus4_q <= '0;
      halt_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      valid_q       <= valid_d;
      instr_q       <= instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      halt_q        <= halt_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc_plus4_q;
  assign fetch_halt     = halt_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_risc_v_mike_fetch_unit.sv
// Bench for risc_v_mike_fetch_unit: directed vector table, a wrap-around
// sequence on a second instance, and random stimulus against a spec model.
module tb_risc_v_mike_fetch_unit;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_A = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_W = 32'hFFFF_FFFC;
  localparam int          N_RANDOM   = 3000;

  logic        clk;
  logic        rst, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rd_data;
  logic        if_id_valid, fetch_halt;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4, fetch_cnt;

  logic        w_rst, w_stall, w_redirect_valid;
  logic [31:0] w_redirect_pc, w_imem_addr, w_imem_rd_data;
  logic        w_if_id_valid, w_fetch_halt;
  logic [31:0] w_if_id_instr, w_if_id_pc, w_if_id_pc_plus4, w_fetch_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // ROM: word 0 holds the boot instruction, the rest tag their own index
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    logic [5:0] idx;
    idx = addr[7:2];
    if (idx == 6'd0) return 32'hffff0437;
    return {16'hC0DE, 10'd0, idx};
  endfunction

  assign imem_rd_data   = rom_word(imem_addr);
  assign w_imem_rd_data = rom_word(w_imem_addr);

  risc_v_mike_fetch_unit #(
    .PC_W(32), .INSTR_W(32), .RESET_PC(RESET_PC_A), .NOP_INSTR(NOP)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rd_data(imem_rd_data),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .fetch_halt(fetch_halt), .fetch_cnt(fetch_cnt)
  );

  risc_v_mike_fetch_unit #(
    .PC_W(32), .INSTR_W(32), .RESET_PC(RESET_PC_W), .NOP_INSTR(NOP)
  ) u_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .imem_addr(w_imem_addr), .imem_rd_data(w_imem_rd_data),
    .if_id_valid(w_if_id_valid), .if_id_instr(w_if_id_instr),
    .if_id_pc(w_if_id_pc), .if_id_pc_plus4(w_if_id_pc_plus4),
    .fetch_halt(w_fetch_halt), .fetch_cnt(w_fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset PCs used by both instances must be word aligned
  initial assert (RESET_PC_A[1:0] == 2'b00 && RESET_PC_W[1:0] == 2'b00)
    else $error("FAIL reset_pc_align: RESET_PC not word aligned");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Directed vector: inputs for one cycle, expected outputs after its edge
  typedef struct {
    logic        rst, stall, rv;
    logic [31:0] rpc;
    logic        e_valid;
    logic [31:0] e_instr, e_pc, e_plus4, e_addr;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic v, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic [31:0] ep4, input logic [31:0] ea, input logic eh,
                     input logic [31:0] ec);
    vec_t t;
    t.rst = r; t.stall = s; t.rv = v; t.rpc = rpc;
    t.e_valid = ev; t.e_instr = ei; t.e_pc = ep; t.e_plus4 = ep4;
    t.e_addr = ea; t.e_halt = eh; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  task automatic check_main(input string tag, input logic ev, input logic [31:0] ei,
                            input logic [31:0] ep, input logic [31:0] ep4,
                            input logic [31:0] ea, input logic eh, input logic [31:0] ec);
    chk({tag, " valid"}, 32'(if_id_valid), 32'(ev));
    chk({tag, " instr"}, if_id_instr, ei);
    chk({tag, " pc"}, if_id_pc, ep);
    chk({tag, " pc_plus4"}, if_id_pc_plus4, ep4);
    chk({tag, " imem_addr"}, imem_addr, ea);
    chk({tag, " halt"}, 32'(fetch_halt), 32'(eh));
    chk({tag, " cnt"}, fetch_cnt, ec);
  endtask

  // Behavioural model of the fetch stage, driven by the rule priorities
  logic        m_boot, m_halted, m_valid;
  logic [31:0] m_pc, m_instr, m_ipc, m_p4, m_cnt;

  task automatic model_step(input logic r, input logic s, input logic v, input logic [31:0] rpc);
    if (r) begin
      m_boot = 1; m_halted = 0; m_valid = 0; m_pc = RESET_PC_A;
      m_instr = NOP; m_ipc = 0; m_p4 = 0; m_cnt = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (v && (rpc % 4 != 0)) begin
      m_halted = 1; m_boot = 0; m_valid = 0; m_instr = NOP;
    end else if (v) begin
      m_boot = 0; m_pc = rpc; m_valid = 0; m_instr = NOP;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!s) begin
      m_valid = 1; m_instr = rom_word(m_pc); m_ipc = m_pc;
      m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_cnt = m_cnt + 32'd1;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    w_rst = 1'b1; w_stall = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = '0;

    //   rst stl rv  rpc      | valid instr            pc     plus4  addr   halt cnt
    add(1, 0, 0, 32'h0,      0, NOP,                 0,     0,     0,     0, 0);
    add(1, 1, 1, 32'h50,     0, NOP,                 0,     0,     0,     0, 0);
    add(0, 0, 0, 32'h0,      0, NOP,                 0,     0,     0,     0, 0);
    add(0, 0, 0, 32'h0,      1, 32'hffff0437,        0,     4,     4,     0, 1);
    add(0, 0, 0, 32'h0,      1, rom_word(4),         4,     8,     8,     0, 2);
    add(0, 0, 0, 32'h0,      1, rom_word(8),         8,     12,    12,    0, 3);
    add(0, 0, 0, 32'h0,      1, rom_word(12),        12,    16,    16,    0, 4);
    add(0, 0, 0, 32'h0,      1, rom_word(16),        16,    20,    20,    0, 5);
    add(0, 1, 0, 32'h0,      1, rom_word(16),        16,    20,    20,    0, 5);
    add(0, 0, 0, 32'h0,      1, rom_word(20),        20,    24,    24,    0, 6);
    add(0, 1, 1, 32'h94,     0, NOP,                 20,    24,    32'h94, 0, 6);
    add(0, 1, 0, 32'h0,      0, NOP,                 20,    24,    32'h94, 0, 6);
    add(0, 0, 0, 32'h0,      1, rom_word(32'h94),    32'h94, 32'h98, 32'h98, 0, 7);
    add(0, 0, 1, 32'h8,      0, NOP,                 32'h94, 32'h98, 8,     0, 7);
    add(0, 1, 0, 32'h0,      0, NOP,                 32'h94, 32'h98, 8,     0, 7);
    add(0, 1, 0, 32'h0,      0, NOP,                 32'h94, 32'h98, 8,     0, 7);
    add(0, 1, 0, 32'h0,      0, NOP,                 32'h94, 32'h98, 8,     0, 7);
    add(0, 0, 0, 32'h0,      1, rom_word(8),         8,     12,    12,    0, 8);
    add(0, 0, 1, 32'h96,     0, NOP,                 8,     12,    12,    1, 8);
    add(0, 0, 1, 32'h100,    0, NOP,                 8,     12,    12,    1, 8);
    add(0, 1, 0, 32'h0,      0, NOP,                 8,     12,    12,    1, 8);
    add(0, 0, 0, 32'h0,      0, NOP,                 8,     12,    12,    1, 8);
    add(0, 1, 1, 32'h97,     0, NOP,                 8,     12,    12,    1, 8);
    add(1, 1, 1, 32'h40,     0, NOP,                 0,     0,     0,     0, 0);
    add(0, 1, 1, 32'h10,     0, NOP,                 0,     0,     32'h10, 0, 0);
    add(0, 0, 0, 32'h0,      1, rom_word(32'h10),    32'h10, 32'h14, 32'h14, 0, 1);
    add(1, 0, 0, 32'h0,      0, NOP,                 0,     0,     0,     0, 0);
    add(0, 0, 1, 32'h22,     0, NOP,                 0,     0,     0,     1, 0);
    add(0, 0, 0, 32'h0,      0, NOP,                 0,     0,     0,     1, 0);
    add(1, 0, 0, 32'h0,      0, NOP,                 0,     0,     0,     0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; stall = vecs[i].stall;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      @(posedge clk); #1;
      check_main($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_pc,
                 vecs[i].e_plus4, vecs[i].e_addr, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // PC wrap on the instance that boots at the top word of the address space
    w_rst = 1'b1;
    @(posedge clk); #1;
    chk("wrap reset addr", w_imem_addr, RESET_PC_W);
    chk("wrap reset valid", 32'(w_if_id_valid), 32'd0);
    w_rst = 1'b0;
    @(posedge clk); #1;
    chk("wrap boot valid", 32'(w_if_id_valid), 32'd0);
    chk("wrap boot addr", w_imem_addr, RESET_PC_W);
    @(posedge clk); #1;
    chk("wrap first valid", 32'(w_if_id_valid), 32'd1);
    chk("wrap first instr", w_if_id_instr, rom_word(RESET_PC_W));
    chk("wrap first pc", w_if_id_pc, RESET_PC_W);
    chk("wrap first plus4", w_if_id_pc_plus4, 32'd0);
    chk("wrap second addr", w_imem_addr, 32'd0);
    chk("wrap halt", 32'(w_fetch_halt), 32'd0);
    @(posedge clk); #1;
    chk("wrap second instr", w_if_id_instr, 32'hffff0437);
    chk("wrap second pc", w_if_id_pc, 32'd0);
    chk("wrap second plus4", w_if_id_pc_plus4, 32'd4);
    chk("wrap cnt", w_fetch_cnt, 32'd2);

    // Random traffic against the model, starting from a reset cycle
    for (int c = 0; c < N_RANDOM; c++) begin
      logic r, s, v, mis;
      logic [31:0] rpc;
      r   = (c == 0) || ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 2) == 0);
      v   = ($urandom_range(0, 7) == 0);
      mis = ($urandom_range(0, 15) == 0);
      rpc = $urandom();
      if (mis) rpc[1:0] = 2'($urandom_range(1, 3));
      else     rpc[1:0] = 2'b00;
      rst = r; stall = s; redirect_valid = v; redirect_pc = rpc;
      model_step(r, s, v, rpc);
      @(posedge clk); #1;
      check_main($sformatf("rand%0d", c), m_valid, m_instr, m_ipc, m_p4, m_pc, m_halted, m_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
